mmio_timer_pwm: RTL and testbench

Parametrised multi-channel timer/PWM peripheral on the CPU MMIO bus, decoded inside the 0xFFFF0000 window.
- Each channel has a down-counting timer with periodic or one-shot mode, plus an independent PWM generator with polarity control.
- A shared prescaler divides the timer tick.
- A sticky W1C interrupt status with per-channel enables drives a single level IRQ to CPU ext_int.

---
 rtl/mmio_timer_pkg.sv | 34 +++
 rtl/mmio_timer_chan.sv | 76 +++++++
 rtl/mmio_timer_pwm.sv | 128 ++++++++++++
 tb/tb_mmio_timer_pwm.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the MMIO timer/PWM block: register offsets, CTRL bit
// positions and the byte-lane write merge helper.
package mmio_timer_pkg;

  // Global register offsets, relative to BASE
  localparam logic [3:0] OFF_STATUS   = 4'h0;
  localparam logic [3:0] OFF_IRQ_EN   = 4'h4;
  localparam logic [3:0] OFF_PRESCALE = 4'h8;

  // Per-channel register offsets, relative to the channel base
  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_LOAD  = 4'h4;
  localparam logic [3:0] OFF_COUNT = 4'h8;
  localparam logic [3:0] OFF_DUTY  = 4'hC;

  localparam logic [15:0] CH_STRIDE = 16'h0010;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_PWM_EN   = 2;
  localparam int CTRL_POL      = 3;
  localparam int CTRL_RELOAD   = 4;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wr_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? wr_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer_chan.sv
// One timer/PWM channel: CTRL/LOAD/COUNT/DUTY registers, down-counter with
// periodic/one-shot behaviour, and a free-running PWM comparator.
module mmio_timer_chan
  import mmio_timer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic             wr_load,
  input  logic             wr_duty,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  output logic [3:0]       ctrl,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] count,
  output logic [PWM_W:0]   duty,
  output logic             expire,
  output logic             pwm_out
);

  logic [31:0]      ctrl_wr, load_wr, duty_wr;
  logic             reload, en, periodic, pwm_en, pol;
  logic [PWM_W-1:0] pwm_cnt;
  logic             unused_bits;

  assign ctrl_wr = be_merge(32'(ctrl), wdata, be);
  assign load_wr = be_merge(32'(load), wdata, be);
  assign duty_wr = be_merge(32'(duty), wdata, be);
  assign unused_bits = ^{ctrl_wr, load_wr, duty_wr};

  assign reload   = wr_ctrl && ctrl_wr[CTRL_RELOAD];
  assign en       = ctrl[CTRL_EN];
  assign periodic = ctrl[CTRL_PERIODIC];
  assign pwm_en   = ctrl[CTRL_PWM_EN];
  assign pol      = ctrl[CTRL_POL];

  // A reload in the expiry cycle replaces the expiry entirely.
  assign expire = tick && en && !reload && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      load    <= '0;
      count   <= '0;
      duty    <= '0;
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_wr[3:0];
      if (wr_load) load <= load_wr[CNT_W-1:0];
      if (wr_duty) duty <= duty_wr[PWM_W:0];

      // RELOAD samples LOAD before any write landing on the same edge.
      if (reload) begin
        count <= load;
      end else if (tick && en) begin
        if (count != '0)   count <= count - CNT_W'(1);
        else if (periodic) count <= load;
        else               ctrl[CTRL_EN] <= 1'b0;
      end

      if (pwm_en) begin
        pwm_cnt <= pwm_cnt + PWM_W'(1);
        pwm_out <= ({1'b0, pwm_cnt} < duty) ^ pol;
      end else begin
        pwm_cnt <= '0;
        pwm_out <= pol;
      end
    end
  end

endmodule

// File: rtl/mmio_timer_pwm.sv
// Multi-channel timer/PWM peripheral: shared prescaler, W1C status with
// per-channel interrupt enables, address decode and read mux.
module mmio_timer_pwm
  import mmio_timer_pkg::*;
#(
  parameter int          N_CH  = 4,
  parameter int          CNT_W = 16,
  parameter int          PWM_W = 8,
  parameter int          PRE_W = 16,
  parameter logic [15:0] BASE  = 16'h0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [15:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            hit,
  output logic            irq,
  output logic [N_CH-1:0] pwm_out
);

  // Bus: sel qualifies a single-cycle access with no wait states; a write
  // commits at the posedge where sel && we, a read is combinational.
  logic [15:0]     off;
  logic [11:0]     blk;
  logic [3:0]      reg_off;
  logic            glb_hit, ch_hit, wr_en, wr_glb;
  logic [N_CH-1:0] status, irq_en, expire;
  logic [PRE_W-1:0] prescale, pre_cnt;
  logic            tick;
  logic [31:0]     stat_wr, irq_wr, pre_wr;
  logic            unused_bits;

  logic [3:0]       ctrl_a  [N_CH];
  logic [CNT_W-1:0] load_a  [N_CH];
  logic [CNT_W-1:0] count_a [N_CH];
  logic [PWM_W:0]   duty_a  [N_CH];

  // blk 0 is the global page, blk 1..N_CH are the channel pages.
  assign off     = addr - BASE;
  assign blk     = off[15:4];
  assign reg_off = {off[3:2], 2'b00};
  assign glb_hit = sel && (blk == 12'd0) && (reg_off != 4'hC);
  assign ch_hit  = sel && (blk != 12'd0) && (blk <= 12'(N_CH));
  assign wr_en   = sel && we;
  assign wr_glb  = wr_en && glb_hit;

  assign stat_wr = be_merge(32'h0, wdata, be);
  assign irq_wr  = be_merge(32'(irq_en), wdata, be);
  assign pre_wr  = be_merge(32'(prescale), wdata, be);
  assign unused_bits = ^{off[1:0], stat_wr, irq_wr, pre_wr};

  assign tick = (pre_cnt == prescale);
  assign irq  = |(status & irq_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      pre_cnt  <= '0;
      irq_en   <= '0;
      status   <= '0;
    end else begin
      if (wr_glb && reg_off == OFF_PRESCALE) begin
        prescale <= pre_wr[PRE_W-1:0];
        pre_cnt  <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      if (wr_glb && reg_off == OFF_IRQ_EN) irq_en <= irq_wr[N_CH-1:0];
      // Hardware set is OR-ed after the clear so a racing W1C loses.
      status <= (status & ~((wr_glb && reg_off == OFF_STATUS) ? stat_wr[N_CH-1:0]
                                                                : '0)) | expire;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en && (blk == 12'(c + 1));
    mmio_timer_chan #(.CNT_W(CNT_W), .PWM_W(PWM_W)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .wr_ctrl (ch_wr && reg_off == OFF_CTRL),
      .wr_load (ch_wr && reg_off == OFF_LOAD),
      .wr_duty (ch_wr && reg_off == OFF_DUTY),
      .wdata   (wdata),
      .be      (be),
      .ctrl    (ctrl_a[c]),
      .load    (load_a[c]),
      .count   (count_a[c]),
      .duty    (duty_a[c]),
      .expire  (expire[c]),
      .pwm_out (pwm_out[c])
    );
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b0;
    if (glb_hit) begin
      hit = 1'b1;
      case (reg_off)
        OFF_STATUS:   rdata = 32'(status);
        OFF_IRQ_EN:   rdata = 32'(irq_en);
        OFF_PRESCALE: rdata = 32'(prescale);
        default:      rdata = '0;
      endcase
    end else if (ch_hit) begin
      hit = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        if (blk == 12'(c + 1)) begin
          case (reg_off)
            OFF_CTRL:  rdata = 32'(ctrl_a[c]);
            OFF_LOAD:  rdata = 32'(load_a[c]);
            OFF_COUNT: rdata = 32'(count_a[c]);
            default:   rdata = 32'(duty_a[c]);
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_timer_pwm.sv
// Self-checking bench for mmio_timer_pwm: directed scenarios plus a random
// register-access phase, all scored against a behavioural register model.
module tb_mmio_timer_pwm;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int PWM_W = 8;
  localparam int PRE_W = 16;
  localparam int BASE  = 'h100;
  localparam int A_STATUS   = BASE;
  localparam int A_IRQ_EN   = BASE + 4;
  localparam int A_PRESCALE = BASE + 8;

  // clock / reset / bus signals
  logic            clk = 1'b0;
  logic            rst, sel, we;
  logic [3:0]      be;
  logic [15:0]     addr;
  logic [31:0]     wdata, rdata;
  logic            hit, irq;
  logic [N_CH-1:0] pwm_out;

  always #50 clk = ~clk;

  mmio_timer_pwm #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PWM_W(PWM_W), .PRE_W(PRE_W), .BASE(16'h0100)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq), .pwm_out(pwm_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_status, m_irq_en, m_prescale, m_pre_cnt;
  int unsigned m_ctrl[N_CH], m_load[N_CH], m_count[N_CH], m_duty[N_CH];
  int unsigned m_pwm_cnt[N_CH], m_pwm_out[N_CH];

  function automatic int a_ch(input int c, input int r);
    return BASE + 16 + 16 * c + 4 * r;
  endfunction

  function automatic void model_reset();
    m_status = 0; m_irq_en = 0; m_prescale = 0; m_pre_cnt = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_ctrl[c] = 0; m_load[c] = 0; m_count[c] = 0; m_duty[c] = 0;
      m_pwm_cnt[c] = 0; m_pwm_out[c] = 0;
    end
  endfunction

  function automatic int unsigned merge(input int unsigned old_v, input int unsigned wd,
                                        input logic [3:0] b);
    int unsigned m = 0;
    for (int i = 0; i < 4; i++) if (b[i]) m = m | (32'hFF << (8 * i));
    return (old_v & ~m) | (wd & m);
  endfunction

  // Returns 0/1/2 for STATUS/IRQ_EN/PRESCALE, 4..7 for CTRL/LOAD/COUNT/DUTY, -1 unmapped.
  function automatic int dec(input int a, output int ch);
    int w = a & 'hFFFC;
    ch = 0;
    if (w >= BASE && w < BASE + 12) return (w - BASE) / 4;
    if (w >= BASE + 16 && w < BASE + 16 + 16 * N_CH) begin
      ch = (w - BASE - 16) / 16;
      return 4 + ((w - BASE) % 16) / 4;
    end
    return -1;
  endfunction

  function automatic int unsigned model_read(input int a);
    int ch;
    case (dec(a, ch))
      0: return m_status;
      1: return m_irq_en;
      2: return m_prescale;
      4: return m_ctrl[ch];
      5: return m_load[ch];
      6: return m_count[ch];
      7: return m_duty[ch];
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned model_hit(input int a);
    int ch;
    return (dec(a, ch) >= 0) ? 1 : 0;
  endfunction

  // One clock edge of the specification's behaviour, using pre-edge values.
  function automatic void model_step();
    int r = -1;
    int ch = 0;
    int unsigned expd = 0;
    int unsigned nctrl, ldold, pol, w1c;
    logic t = (m_pre_cnt == m_prescale);
    if (sel && we) r = dec(int'(addr), ch);
    for (int c = 0; c < N_CH; c++) begin
      ldold = m_load[c];
      nctrl = m_ctrl[c];
      if (r == 4 && ch == c) nctrl = merge(m_ctrl[c], wdata, be) & 'hF;
      if (r == 4 && ch == c && be[0] && wdata[4]) begin
        m_count[c] = ldold;
      end else if (t && (m_ctrl[c] & 1) != 0) begin
        if (m_count[c] != 0) m_count[c] = m_count[c] - 1;
        else begin
          expd = expd | (1 << c);
          if ((m_ctrl[c] & 2) != 0) m_count[c] = ldold;
          else nctrl = nctrl & ~32'd1;
        end
      end
      pol = (m_ctrl[c] >> 3) & 1;
      if ((m_ctrl[c] & 4) != 0) begin
        m_pwm_out[c] = ((m_pwm_cnt[c] < m_duty[c]) ? 1 : 0) ^ pol;
        m_pwm_cnt[c] = (m_pwm_cnt[c] + 1) % (1 << PWM_W);
      end else begin
        m_pwm_cnt[c] = 0;
        m_pwm_out[c] = pol;
      end
      if (r == 5 && ch == c) m_load[c] = merge(m_load[c], wdata, be) & ((1 << CNT_W) - 1);
      if (r == 7 && ch == c) m_duty[c] = merge(m_duty[c], wdata, be) & ((2 << PWM_W) - 1);
      m_ctrl[c] = nctrl;
    end
    w1c = (r == 0) ? (merge(0, wdata, be) & ((1 << N_CH) - 1)) : 0;
    m_status = (m_status & ~w1c) | expd;
    if (r == 1) m_irq_en = merge(m_irq_en, wdata, be) & ((1 << N_CH) - 1);
    if (r == 2) begin
      m_prescale = merge(m_prescale, wdata, be) & ((1 << PRE_W) - 1);
      m_pre_cnt = 0;
    end else if (t) m_pre_cnt = 0;
    else m_pre_cnt = m_pre_cnt + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < N_CH; c++) chk("pwm_cycle", 32'(pwm_out[c]), m_pwm_out[c]);
    chk("irq_cycle", 32'(irq), ((m_status & m_irq_en) != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] b);
    sel = 1'b1; we = 1'b1; addr = 16'(a); wdata = d; be = b;
    step_clk();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic get_reg(input int a, output logic [31:0] v);
    sel = 1'b1; we = 1'b0; addr = 16'(a);
    #1;
    v = rdata;
    sel = 1'b0;
  endtask

  task automatic check_reg(input int a, input string tag);
    sel = 1'b1; we = 1'b0; addr = 16'(a);
    #1;
    chk({tag, "_rd"}, rdata, model_read(a));
    chk({tag, "_hit"}, 32'(hit), model_hit(a));
    sel = 1'b0;
  endtask

  task automatic read_all(input string tag);
    check_reg(A_STATUS, tag);
    check_reg(A_IRQ_EN, tag);
    check_reg(A_PRESCALE, tag);
    for (int c = 0; c < N_CH; c++)
      for (int r = 0; r < 4; r++) check_reg(a_ch(c, r), tag);
  endtask

  task automatic pwm_window(input int c, input int exp_hi, input string tag);
    int hi = 0;
    repeat (2) step_clk();
    for (int i = 0; i < 256; i++) begin
      step_clk();
      hi += int'(pwm_out[c]);
    end
    chk(tag, 32'(hi), 32'(exp_hi));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] v;
    int seq[5];
    int g, edges, k, ch, r;
    int a;
    logic [31:0] d;

    rst = 1'b1; sel = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    read_all("reset");
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    rst = 1'b0;

    // periodic timer, tick every clock
    bus_write(A_PRESCALE, 0, 4'hF);
    bus_write(a_ch(0, 1), 3, 4'hF);
    bus_write(A_IRQ_EN, 1, 4'hF);
    bus_write(a_ch(0, 0), 'h13, 4'hF);
    seq = '{3, 2, 1, 0, 3};
    for (int i = 0; i < 5; i++) begin
      get_reg(a_ch(0, 2), v);
      chk("periodic_count", v, 32'(seq[i]));
      get_reg(A_STATUS, v);
      chk("periodic_status", v & 1, (i == 4) ? 32'd1 : 32'd0);
      check_reg(a_ch(0, 2), "periodic_model");
      if (i < 4) step_clk();
    end
    chk("periodic_irq_high", 32'(irq), 32'd1);
    bus_write(a_ch(0, 0), 0, 4'hF);
    repeat (3) step_clk();
    chk("irq_held", 32'(irq), 32'd1);
    bus_write(A_STATUS, 1, 4'hF);
    chk("irq_cleared", 32'(irq), 32'd0);

    // W1C racing a hardware set
    bus_write(a_ch(0, 0), 'h13, 4'hF);
    g = 0;
    while (!(m_pre_cnt == m_prescale && (m_ctrl[0] & 1) != 0 && m_count[0] == 0) && g < 16) begin
      step_clk();
      g++;
    end
    chk("race_found", (g < 16) ? 32'd1 : 32'd0, 32'd1);
    get_reg(a_ch(0, 2), v);
    chk("race_count0", v, 32'd0);
    bus_write(A_STATUS, 1, 4'h1);
    get_reg(A_STATUS, v);
    chk("race_status", v & 1, 32'd1);
    bus_write(a_ch(0, 0), 0, 4'hF);
    bus_write(A_STATUS, 'hF, 4'hF);
    get_reg(A_STATUS, v);
    chk("race_cleared", v, 32'd0);

    // one-shot behind a /3 prescaler
    bus_write(A_PRESCALE, 2, 4'hF);
    bus_write(a_ch(0, 1), 1, 4'hF);
    bus_write(a_ch(0, 0), 'h11, 4'hF);
    edges = 2;
    get_reg(A_STATUS, v);
    while ((v & 1) == 0 && edges < 30) begin
      step_clk();
      edges++;
      get_reg(A_STATUS, v);
    end
    chk("oneshot_latency", 32'(edges), 32'd6);
    get_reg(a_ch(0, 0), v);
    chk("oneshot_en_clear", v, 32'd0);
    bus_write(A_STATUS, 1, 4'hF);
    repeat (12) step_clk();
    get_reg(A_STATUS, v);
    chk("oneshot_no_reset", v, 32'd0);
    get_reg(a_ch(0, 2), v);
    chk("oneshot_count_hold", v, 32'd0);

    // PWM duty and polarity on channel 1
    bus_write(a_ch(1, 3), 64, 4'hF);
    bus_write(a_ch(1, 0), 'h4, 4'hF);
    pwm_window(1, 64, "pwm_d64");
    bus_write(a_ch(1, 3), 0, 4'hF);
    pwm_window(1, 0, "pwm_d0");
    bus_write(a_ch(1, 3), 256, 4'hF);
    pwm_window(1, 256, "pwm_d256");
    bus_write(a_ch(1, 0), 'hC, 4'hF);
    pwm_window(1, 0, "pwm_d256_inv");
    bus_write(a_ch(1, 3), 0, 4'hF);
    pwm_window(1, 256, "pwm_d0_inv");
    bus_write(a_ch(1, 3), 64, 4'hF);
    pwm_window(1, 192, "pwm_d64_inv");

    // bus edges
    bus_write(a_ch(0, 1), 32'hAABBCCDD, 4'b0001);
    get_reg(a_ch(0, 1), v);
    chk("be_lane0", v, 32'h0000_00DD);
    bus_write(a_ch(0, 2), 32'h1234, 4'hF);
    get_reg(a_ch(0, 2), v);
    chk("count_ro", v, 32'd0);
    sel = 1'b1; we = 1'b0; addr = 16'(a_ch(N_CH, 0));
    #1;
    chk("unmapped_rd", rdata, 32'd0);
    chk("unmapped_hit", 32'(hit), 32'd0);
    sel = 1'b0; addr = 16'(A_IRQ_EN);
    #1;
    chk("nosel_rd", rdata, 32'd0);
    chk("nosel_hit", 32'(hit), 32'd0);

    // random register traffic
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 5) begin
        r = $urandom_range(0, 3 + 4 * N_CH + 2);
        d = $urandom;
        if (r == 0) a = A_STATUS;
        else if (r == 1) a = A_IRQ_EN;
        else if (r == 2) begin a = A_PRESCALE; d = $urandom_range(0, 3); end
        else if (r < 3 + 4 * N_CH) begin
          ch = (r - 3) / 4;
          a = a_ch(ch, (r - 3) % 4);
          case ((r - 3) % 4)
            0: d = $urandom_range(0, 31);
            1: d = $urandom_range(0, 6);
            3: d = $urandom_range(0, 511);
            default: d = $urandom;
          endcase
        end else if (r == 3 + 4 * N_CH) a = BASE + 12;
        else a = a_ch(N_CH, $urandom_range(0, 3));
        a = a | $urandom_range(0, 3);
        bus_write(a, d, 4'($urandom_range(1, 15)));
      end else if (k <= 8) begin
        r = $urandom_range(0, 6);
        if (r < 3) a = BASE + 4 * r;
        else if (r == 3) a = BASE + 12;
        else if (r == 4) a = a_ch(N_CH, 1);
        else a = a_ch($urandom_range(0, N_CH - 1), $urandom_range(0, 3));
        check_reg(a | $urandom_range(0, 3), "rand");
        step_clk();
      end else begin
        repeat ($urandom_range(1, 5)) step_clk();
      end
    end
    read_all("rand_end");

    // asynchronous reset in the middle of a clock phase
    bus_write(A_IRQ_EN, 'hF, 4'hF);
    bus_write(a_ch(2, 0), 'h8, 4'hF);
    step_clk();
    chk("pre_rst_pwm2", 32'(pwm_out[2]), 32'd1);
    @(posedge clk);
    model_step();
    #20;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_irq", 32'(irq), 32'd0);
    chk("async_rst_pwm", 32'(pwm_out), 32'd0);
    read_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step_clk();
    read_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
